// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: state enum, opcode constants and datapath select encodings
// shared by the multicycle controller and its ALU decoder.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic op_legal(input logic [6:0] op);
        return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
               op == OP_BEQ || op == OP_JAL;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction/status inputs and control outputs between the
// datapath (master) and the controller (slave).
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       illegal_op;

    modport master (
        output op, funct3, funct7b5, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, illegal_op
    );

    modport slave (
        input  op, funct3, funct7b5, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, illegal_op
    );
endinterface

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: maps ALUOp plus funct fields to the ALU operation code.
module alu_decoder
    import mc_controller_pkg::*;
(
    input  logic [1:0] ALUOp_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] ALUControl_o
);
    logic [2:0] funct_ctl;

    always_comb begin
        funct_ctl = ALU_ADD;
        case (funct3_i)
            3'b000:  funct_ctl = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctl = ALU_SLT;
            3'b110:  funct_ctl = ALU_OR;
            3'b111:  funct_ctl = ALU_AND;
            default: funct_ctl = ALU_ADD;
        endcase
        ALUControl_o = ALUOp_i == ALUOP_FUNCT ? funct_ctl :
                       ALUOp_i == ALUOP_SUB   ? ALU_SUB   : ALU_ADD;
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore multicycle RISC-V control FSM; only PCWrite, IRWrite and
// ALUControl look at inputs, plus the illegal-opcode pulse in DECODE.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mc_controller_if.slave  bus
);
    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic [2:0] alu_ctl;

    always_ff @(posedge clk) begin
        state_q <= rst ? S_FETCH : state_d;
    end

    always_comb begin
        state_d        = state_q;
        alu_op         = ALUOP_ADD;
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ALUSrcA    = SRCA_PC;
        bus.ALUSrcB    = SRCB_REG;
        bus.illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.ResultSrc = RES_ALU;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.ALUSrcA    = SRCA_OLDPC;
                bus.ALUSrcB    = SRCB_IMM;
                bus.illegal_op = !op_legal(bus.op);
                state_d = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR   :
                          bus.op == OP_R                       ? S_EXECUTER :
                          bus.op == OP_I                       ? S_EXECUTEI :
                          bus.op == OP_BEQ                     ? S_BEQ      :
                          bus.op == OP_JAL                     ? S_JAL      : S_FETCH;
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_REG;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = bus.op == OP_LW ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                state_d    = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_RDATA;
                bus.RegWrite  = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                state_d      = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                bus.ALUSrcA = SRCA_REG;
                alu_op      = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                bus.ALUSrcA = SRCA_REG;
                bus.ALUSrcB = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                state_d      = S_FETCH;
            end
            S_BEQ: begin
                bus.ALUSrcA = SRCA_REG;
                alu_op      = ALUOP_SUB;
                bus.PCWrite = bus.zero;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCWrite = 1'b1;
                state_d     = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset overrides the decode of whatever state we were caught in.
        if (rst) begin
            alu_op         = ALUOP_ADD;
            bus.PCWrite    = 1'b0;
            bus.AdrSrc     = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.illegal_op = 1'b0;
            bus.ResultSrc  = RES_ALU;
            bus.ALUSrcA    = SRCA_PC;
            bus.ALUSrcB    = SRCB_FOUR;
        end
    end

    alu_decoder u_alu_decoder (
        .ALUOp_i     (alu_op),
        .funct3_i    (bus.funct3),
        .funct7b5_i  (bus.funct7b5),
        .op5_i       (bus.op[5]),
        .ALUControl_o(alu_ctl)
    );

    assign bus.ALUControl = alu_ctl;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed per-cycle stimulus pushes hand-computed output
// vectors into a scoreboard; a negedge monitor pops and compares.
module tb_mc_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        string      nm;
        logic [14:0] exp;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    logic [14:0] act;

    mc_controller_if bus();

    mc_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Vector layout: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUControl illegal_op
    function automatic logic [14:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, ill};
    endfunction

    logic [14:0] e_rst, e_f1, e_dec, e_ill, e_madr, e_mrd, e_mwb, e_mwr, e_awb, e_jal;

    function automatic logic [14:0] e_exr(input logic [2:0] ac);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ac, 0);
    endfunction

    function automatic logic [14:0] e_exi(input logic [2:0] ac);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ac, 0);
    endfunction

    function automatic logic [14:0] e_beq(input logic z);
        return mk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
    endfunction

    task automatic step(input string nm, input logic r, input logic [6:0] o,
                        input logic [2:0] f3, input logic f7, input logic z,
                        input logic mr, input logic [14:0] e);
        @(posedge clk);
        #1;
        rst          = r;
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.zero     = z;
        bus.mem_ready = mr;
        sbq.push_back('{nm: nm, exp: e});
    endtask

    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            cur = sbq.pop_front();
            act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                   bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.illegal_op};
            total++;
            if (act !== cur.exp) begin
                bad++;
                $display("FAIL %s: got %b want %b", cur.nm, act, cur.exp);
            end
        end
    end

    initial begin
        e_rst  = mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        e_f1   = mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
        e_dec  = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0);
        e_ill  = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 1);
        e_madr = mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
        e_mrd  = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        e_mwb  = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);
        e_mwr  = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        e_awb  = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        e_jal  = mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);
        bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;

        step("rst0", 1, 7'b0000011, 3'b010, 0, 0, 1, e_rst);
        step("rst1", 1, 7'b0000011, 3'b010, 0, 0, 1, e_rst);
        // lw, mem_ready=1: 5 cycles
        step("lw_fetch",  0, 7'b0000011, 3'b010, 0, 0, 1, e_f1);
        step("lw_decode", 0, 7'b0000011, 3'b010, 0, 0, 1, e_dec);
        step("lw_memadr", 0, 7'b0000011, 3'b010, 0, 0, 1, e_madr);
        step("lw_memrd",  0, 7'b0000011, 3'b010, 0, 0, 1, e_mrd);
        step("lw_memwb",  0, 7'b0000011, 3'b010, 0, 0, 1, e_mwb);
        // sw with three wait cycles in MEMWRITE
        step("sw_fetch",  0, 7'b0100011, 3'b010, 0, 0, 1, e_f1);
        step("sw_decode", 0, 7'b0100011, 3'b010, 0, 0, 1, e_dec);
        step("sw_memadr", 0, 7'b0100011, 3'b010, 0, 0, 1, e_madr);
        step("sw_wait0",  0, 7'b0100011, 3'b010, 0, 0, 0, e_mwr);
        step("sw_wait1",  0, 7'b0100011, 3'b010, 0, 0, 0, e_mwr);
        step("sw_wait2",  0, 7'b0100011, 3'b010, 0, 0, 0, e_mwr);
        step("sw_done",   0, 7'b0100011, 3'b010, 0, 0, 1, e_mwr);
        // R sub, with a stalled fetch first
        step("sub_fstall", 0, 7'b0110011, 3'b000, 1, 0, 0, e_rst);
        step("sub_fetch",  0, 7'b0110011, 3'b000, 1, 0, 1, e_f1);
        step("sub_decode", 0, 7'b0110011, 3'b000, 1, 0, 1, e_dec);
        step("sub_exec",   0, 7'b0110011, 3'b000, 1, 0, 1, e_exr(3'b001));
        step("sub_wb",     0, 7'b0110011, 3'b000, 1, 0, 1, e_awb);
        // R or
        step("or_fetch",  0, 7'b0110011, 3'b110, 0, 0, 1, e_f1);
        step("or_decode", 0, 7'b0110011, 3'b110, 0, 0, 1, e_dec);
        step("or_exec",   0, 7'b0110011, 3'b110, 0, 0, 1, e_exr(3'b011));
        step("or_wb",     0, 7'b0110011, 3'b110, 0, 0, 1, e_awb);
        // R and / slt, exec only checked after short sequences
        step("and_fetch",  0, 7'b0110011, 3'b111, 0, 0, 1, e_f1);
        step("and_decode", 0, 7'b0110011, 3'b111, 0, 0, 1, e_dec);
        step("and_exec",   0, 7'b0110011, 3'b111, 0, 0, 1, e_exr(3'b010));
        step("and_wb",     0, 7'b0110011, 3'b111, 0, 0, 1, e_awb);
        // addi with funct7b5=1 must stay add since op[5]=0
        step("addi_fetch",  0, 7'b0010011, 3'b000, 1, 0, 1, e_f1);
        step("addi_decode", 0, 7'b0010011, 3'b000, 1, 0, 1, e_dec);
        step("addi_exec",   0, 7'b0010011, 3'b000, 1, 0, 1, e_exi(3'b000));
        step("addi_wb",     0, 7'b0010011, 3'b000, 1, 0, 1, e_awb);
        // slti
        step("slti_fetch",  0, 7'b0010011, 3'b010, 0, 0, 1, e_f1);
        step("slti_decode", 0, 7'b0010011, 3'b010, 0, 0, 1, e_dec);
        step("slti_exec",   0, 7'b0010011, 3'b010, 0, 0, 1, e_exi(3'b101));
        step("slti_wb",     0, 7'b0010011, 3'b010, 0, 0, 1, e_awb);
        // beq taken / not taken
        step("beqt_fetch",  0, 7'b1100011, 3'b000, 0, 1, 1, e_f1);
        step("beqt_decode", 0, 7'b1100011, 3'b000, 0, 1, 1, e_dec);
        step("beqt_beq",    0, 7'b1100011, 3'b000, 0, 1, 1, e_beq(1'b1));
        step("beqn_fetch",  0, 7'b1100011, 3'b000, 0, 0, 1, e_f1);
        step("beqn_decode", 0, 7'b1100011, 3'b000, 0, 0, 1, e_dec);
        step("beqn_beq",    0, 7'b1100011, 3'b000, 0, 0, 1, e_beq(1'b0));
        // jal
        step("jal_fetch",  0, 7'b1101111, 3'b000, 0, 0, 1, e_f1);
        step("jal_decode", 0, 7'b1101111, 3'b000, 0, 0, 1, e_dec);
        step("jal_jal",    0, 7'b1101111, 3'b000, 0, 0, 1, e_jal);
        step("jal_wb",     0, 7'b1101111, 3'b000, 0, 0, 1, e_awb);
        // illegal opcode: one-cycle pulse, then FETCH
        step("ill_fetch",  0, 7'b1111111, 3'b000, 0, 0, 1, e_f1);
        step("ill_decode", 0, 7'b1111111, 3'b000, 0, 0, 1, e_ill);
        step("ill_after",  0, 7'b1111111, 3'b000, 0, 0, 0, e_rst);
        // reset in the middle of a stalled MEMREAD
        step("rlw_fetch",  0, 7'b0000011, 3'b010, 0, 0, 1, e_f1);
        step("rlw_decode", 0, 7'b0000011, 3'b010, 0, 0, 1, e_dec);
        step("rlw_memadr", 0, 7'b0000011, 3'b010, 0, 0, 1, e_madr);
        step("rlw_memrd",  0, 7'b0000011, 3'b010, 0, 0, 0, e_mrd);
        step("rlw_inrst",  1, 7'b0000011, 3'b010, 0, 1, 1, e_rst);
        step("rlw_after",  0, 7'b0000011, 3'b010, 0, 0, 1, e_f1);
        step("rlw_decode2", 0, 7'b0000011, 3'b010, 0, 0, 1, e_dec);

        @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
